// File: rtl/wb_ctrl_pipe.sv
// Writeback control pipeline: decodes RV32I/F instructions into writeback
// controls, carries them DEPTH register stages and flags load-use hazards.
module wb_ctrl_pipe #(
    parameter int DEPTH    = 2,
    parameter int UART_BIT = 31,
    parameter int FP_EN    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] inst,
    input  logic [31:0] addr,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        wb_valid,
    output logic [1:0]  wbsel,
    output logic [1:0]  dsel,
    output logic        regwen,
    output logic        fp_regwen,
    output logic [4:0]  rd,
    output logic [2:0]  ld_funct3,
    output logic [1:0]  ld_off,
    output logic        load_use,
    output logic        busy
);

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] D_DMEM = 2'd0;
    localparam logic [1:0] D_UART = 2'd1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LOADFP = 7'b0000111;
    localparam logic [6:0] OPC_OPFP   = 7'b1010011;

    typedef struct packed {
        logic [1:0] wbsel;
        logic [1:0] dsel;
        logic       regwen;
        logic       fp_regwen;
        logic       ild;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] off;
    } ctl_t;

    ctl_t             dec_c;
    ctl_t             st_q [DEPTH];
    ctl_t             st_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] f7hi;
    logic [1:0] mem_src;

    assign opc     = inst[6:0];
    assign f3      = inst[14:12];
    assign f7hi    = inst[31:27];
    assign mem_src = addr[UART_BIT] ? D_UART : D_DMEM;

    // Instruction decode; anything not matched leaves the safe defaults
    always_comb begin
        dec_c           = '0;
        dec_c.wbsel     = WB_ALU;
        dec_c.dsel      = D_DMEM;
        dec_c.rd        = inst[11:7];
        dec_c.funct3    = f3;
        dec_c.off       = addr[1:0];
        case (opc)
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: dec_c.regwen = 1'b1;
            OPC_JAL, OPC_JALR: begin
                dec_c.wbsel  = WB_PC4;
                dec_c.regwen = 1'b1;
            end
            OPC_LOAD: begin
                if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    dec_c.wbsel  = WB_MEM;
                    dec_c.dsel   = mem_src;
                    dec_c.regwen = 1'b1;
                    dec_c.ild    = 1'b1;
                end
            end
            OPC_LOADFP: begin
                if (FP_EN != 0 && f3 == 3'b010) begin
                    dec_c.wbsel     = WB_MEM;
                    dec_c.dsel      = mem_src;
                    dec_c.fp_regwen = 1'b1;
                end
            end
            OPC_OPFP: begin
                if (FP_EN != 0) begin
                    if (f7hi inside {5'b10100, 5'b11000, 5'b11100}) begin
                        dec_c.regwen = 1'b1;
                    end else begin
                        dec_c.fp_regwen = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // x0 is never written, so it can never be a hazard source either
        if (inst[11:7] == 5'd0) begin
            dec_c.regwen = 1'b0;
            dec_c.ild    = 1'b0;
        end
    end

    // Stage advance: stall holds everything, flush kills the youngest slot
    always_comb begin
        v_d  = v_q;
        st_d = st_q;
        if (!stall) begin
            for (int i = 1; i < DEPTH; i++) begin
                v_d[i]  = v_q[i-1] & ~((i == 1) & flush);
                st_d[i] = st_q[i-1];
            end
            v_d[0]  = in_valid & ~flush;
            st_d[0] = dec_c;
        end else if (flush) begin
            v_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i] <= '0;
            end
        end else begin
            v_q  <= v_d;
            st_q <= st_d;
        end
    end

    assign wb_valid  = v_q[DEPTH-1];
    assign regwen    = v_q[DEPTH-1] & st_q[DEPTH-1].regwen;
    assign fp_regwen = v_q[DEPTH-1] & st_q[DEPTH-1].fp_regwen;
    assign wbsel     = v_q[DEPTH-1] ? st_q[DEPTH-1].wbsel  : WB_ALU;
    assign dsel      = v_q[DEPTH-1] ? st_q[DEPTH-1].dsel   : D_DMEM;
    assign rd        = v_q[DEPTH-1] ? st_q[DEPTH-1].rd     : 5'd0;
    assign ld_funct3 = v_q[DEPTH-1] ? st_q[DEPTH-1].funct3 : 3'd0;
    assign ld_off    = v_q[DEPTH-1] ? st_q[DEPTH-1].off    : 2'd0;
    assign busy      = |v_q;

    // Integer loads still ahead of writeback whose rd matches a source
    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (v_q[i] && st_q[i].ild &&
                (st_q[i].rd == rs1 || st_q[i].rd == rs2)) begin
                load_use = 1'b1;
            end
        end
    end

endmodule
